// File: rtl/xip_burst_reader_if.sv
// Bundle of control, AXI4-Lite read and output-stream signals for xip_burst_reader.
// The master modport is the reader's own view; slave is the environment's view.
interface xip_burst_reader_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  start_i;
  logic [ADDR_WIDTH-1:0] base_addr_i;
  logic [CNT_WIDTH-1:0]  word_count_i;
  logic                  abort_i;
  logic [ADDR_WIDTH-1:0] araddr_o;
  logic                  arvalid_o;
  logic                  arready_i;
  logic [31:0]           rdata_i;
  logic [1:0]            rresp_i;
  logic                  rvalid_i;
  logic                  rready_o;
  logic [31:0]           data_o;
  logic                  data_valid_o;
  logic                  data_ready_i;
  logic                  busy_o;
  logic                  done_o;
  logic                  error_o;
  logic [CNT_WIDTH-1:0]  words_done_o;

  modport master (
    input  start_i, base_addr_i, word_count_i, abort_i,
    input  arready_i, rdata_i, rresp_i, rvalid_i, data_ready_i,
    output araddr_o, arvalid_o, rready_o, data_o, data_valid_o,
    output busy_o, done_o, error_o, words_done_o
  );

  modport slave (
    output start_i, base_addr_i, word_count_i, abort_i,
    output arready_i, rdata_i, rresp_i, rvalid_i, data_ready_i,
    input  araddr_o, arvalid_o, rready_o, data_o, data_valid_o,
    input  busy_o, done_o, error_o, words_done_o
  );
endinterface

// File: rtl/xip_burst_reader.sv
// AXI4-Lite read master: fetches a block of 32-bit words from the XIP window with
// one read outstanding at a time and forwards each word to a valid/ready stream.
module xip_burst_reader #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input logic clk,
  input logic reset,
  xip_burst_reader_if.master bus
);
  typedef enum logic [2:0] {IDLE, AR, R, DRAIN, FIN} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [CNT_WIDTH-1:0]  remaining;
  logic [CNT_WIDTH-1:0]  words_done;
  logic [31:0]           data_q;
  logic                  data_vld;
  logic                  abort_pend;
  logic                  err;
  logic                  busy;
  logic                  done;

  logic start_ok, abort_now, in_xfer, ar_hs, r_hs, r_bad, r_keep, out_hs;

  always_comb begin
    start_ok  = (state == IDLE) && bus.start_i;
    abort_now = abort_pend || bus.abort_i;
    in_xfer   = (state == AR) || (state == R) || (state == DRAIN);
    ar_hs     = (state == AR) && bus.arready_i;
    // A beat is only taken when the output register can hold it this cycle.
    r_hs      = (state == R) && bus.rvalid_i && (!data_vld || bus.data_ready_i);
    r_bad     = (bus.rresp_i != 2'b00);
    r_keep    = r_hs && !r_bad && !abort_now;
    out_hs    = data_vld && bus.data_ready_i;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = (bus.word_count_i == '0) ? FIN : AR;
      AR:      if (ar_hs) state_nxt = R;
      R:       if (r_hs) state_nxt = (!r_keep || remaining == CNT_WIDTH'(1)) ? DRAIN : AR;
      DRAIN:   if (abort_now || !data_vld || bus.data_ready_i) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr       <= '0;
      remaining  <= '0;
      words_done <= '0;
      data_q     <= '0;
      data_vld   <= 1'b0;
      abort_pend <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= (state == FIN);

      if (start_ok) busy <= 1'b1;
      else if (state == FIN) busy <= 1'b0;

      if (state == FIN) abort_pend <= 1'b0;
      else if (bus.abort_i && in_xfer) abort_pend <= 1'b1;

      if (start_ok) err <= 1'b0;
      else if ((bus.abort_i && in_xfer) || (r_hs && r_bad)) err <= 1'b1;

      // Address wraps naturally at the top of the address space.
      if (start_ok) begin
        addr      <= bus.base_addr_i & ~ADDR_WIDTH'(3);
        remaining <= bus.word_count_i;
      end else if (r_keep) begin
        addr      <= addr + ADDR_WIDTH'(4);
        remaining <= remaining - CNT_WIDTH'(1);
      end

      if (r_keep) begin
        data_q   <= bus.rdata_i;
        data_vld <= 1'b1;
      end else if (out_hs || (state == DRAIN && abort_now)) begin
        data_vld <= 1'b0;
      end

      if (start_ok) words_done <= '0;
      else if (out_hs) words_done <= words_done + CNT_WIDTH'(1);
    end
  end

  assign bus.araddr_o     = addr;
  assign bus.arvalid_o    = (state == AR);
  assign bus.rready_o     = (state == R) && (!data_vld || bus.data_ready_i);
  assign bus.data_o       = data_q;
  assign bus.data_valid_o = data_vld;
  assign bus.busy_o       = busy;
  assign bus.done_o       = done;
  assign bus.error_o      = err;
  assign bus.words_done_o = words_done;
endmodule

// File: tb/tb_xip_burst_reader.sv
// Bench for xip_burst_reader: an AXI4-Lite slave and stream sink with random timing,
// checked against address/word lists computed directly from the transfer rules.
module tb_xip_burst_reader;
  localparam int AW = 32;
  localparam int CW = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  xip_burst_reader_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();
  xip_burst_reader #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int failures = 0;

  // Environment configuration, written only by the test tasks.
  int          epoch = 0;
  int          cfg_ar_max = 0, cfg_r_max = 0, cfg_ready_pct = 100, cfg_hold = 0, cfg_err_beat = -1;
  bit          cfg_ar_rand = 0, cfg_r_rand = 0, cfg_tab_en = 0;
  logic [31:0] tab [4];

  // Environment observations, written only by the env process.
  logic [31:0] ar_log[$];
  logic [31:0] out_log[$];
  int          done_cnt, r_hs_cnt, hold_r_cnt, ar_viol, stab_viol, stall_cyc;
  int          seen_epoch = 0, beat = 0, ar_wait = 0, rlat = 0, hold = 0;
  bit          have_addr = 0, first_seen = 0, prev_ar_stall = 0, prev_d_stall = 0;
  logic [31:0] raddr, prev_araddr, prev_data;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'h3C5A_96E1) * 32'h0001_0003 + 32'h1234_5678;
  endfunction

  function automatic int ar_reload();
    return cfg_ar_rand ? int'($urandom_range(cfg_ar_max, 0)) : cfg_ar_max;
  endfunction

  function automatic int r_reload();
    return cfg_r_rand ? int'($urandom_range(cfg_r_max, 0)) : cfg_r_max;
  endfunction

  // Slave + sink: drive on the falling edge, log the handshakes the next rising edge takes.
  initial begin : env
    bus.arready_i = 1'b0; bus.rvalid_i = 1'b0; bus.rdata_i = '0; bus.rresp_i = '0;
    bus.data_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      if (epoch != seen_epoch) begin
        seen_epoch = epoch;
        ar_log.delete(); out_log.delete();
        done_cnt = 0; r_hs_cnt = 0; hold_r_cnt = 0; ar_viol = 0; stab_viol = 0; stall_cyc = 0;
        beat = 0; first_seen = 0; hold = 0; ar_wait = ar_reload();
      end
      if (reset) begin
        have_addr = 0; bus.arready_i = 1'b0; bus.rvalid_i = 1'b0; bus.data_ready_i = 1'b1;
        prev_ar_stall = 0; prev_d_stall = 0;
      end else begin
        if (!have_addr) bus.rvalid_i = 1'b0;
        bus.arready_i = 1'b0;
        if (bus.arvalid_o && !have_addr) begin
          if (ar_wait > 0) ar_wait--;
          else bus.arready_i = 1'b1;
        end
        if (have_addr && !bus.rvalid_i) begin
          if (rlat > 0) rlat--;
          else begin
            bus.rvalid_i = 1'b1;
            bus.rdata_i  = cfg_tab_en ? tab[beat % 4] : mem_word(raddr);
            bus.rresp_i  = (beat == cfg_err_beat) ? 2'b10 : 2'b00;
          end
        end
        if (cfg_hold > 0 && bus.data_valid_o && !first_seen) begin
          first_seen = 1; hold = cfg_hold;
        end
        if (hold > 0) begin
          bus.data_ready_i = 1'b0; hold--;
        end else begin
          bus.data_ready_i = (int'($urandom_range(99, 0)) < cfg_ready_pct);
        end
        #1;
        if (prev_ar_stall && (!bus.arvalid_o || bus.araddr_o !== prev_araddr)) ar_viol++;
        if (prev_d_stall && (!bus.data_valid_o || bus.data_o !== prev_data)) stab_viol++;
        prev_ar_stall = bus.arvalid_o && !bus.arready_i;
        prev_araddr   = bus.araddr_o;
        prev_d_stall  = bus.data_valid_o && !bus.data_ready_i;
        prev_data     = bus.data_o;
        if (prev_d_stall) stall_cyc++;
        if (bus.done_o) done_cnt++;
        if (bus.arvalid_o && bus.arready_i) begin
          ar_log.push_back(bus.araddr_o);
          have_addr = 1; raddr = bus.araddr_o; rlat = r_reload(); ar_wait = ar_reload();
        end
        if (bus.rvalid_i && bus.rready_o) begin
          r_hs_cnt++;
          if (bus.data_valid_o && !bus.data_ready_i) hold_r_cnt++;
          have_addr = 0; beat++;
        end
        if (bus.data_valid_o && bus.data_ready_i) out_log.push_back(bus.data_o);
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run_xfer(input logic [31:0] base, input logic [15:0] cnt,
                          output bit busy_seen, output bit timed_out);
    tick();
    epoch++;
    bus.base_addr_i = base; bus.word_count_i = cnt; bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    busy_seen = bus.busy_o;
    timed_out = 1;
    for (int i = 0; i < 3000; i++) begin
      if (done_cnt != 0) begin timed_out = 0; break; end
      tick();
    end
    tick(); tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++; if (bus.arvalid_o !== 1'b0) begin failures++; $display("FAIL reset_arvalid got=%0h exp=0", bus.arvalid_o); end
    checks++; if (bus.araddr_o !== '0) begin failures++; $display("FAIL reset_araddr got=%h exp=0", bus.araddr_o); end
    checks++; if ({bus.busy_o, bus.done_o, bus.error_o, bus.data_valid_o, bus.rready_o} !== 5'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=00000", {bus.busy_o, bus.done_o, bus.error_o, bus.data_valid_o, bus.rready_o}); end
    checks++; if (bus.data_o !== '0 || bus.words_done_o !== '0) begin
      failures++; $display("FAIL reset_data got=%h/%0d exp=0/0", bus.data_o, bus.words_done_o); end
    reset = 1'b0;
    tick(); tick();
    checks++; if (bus.busy_o !== 1'b0 || bus.arvalid_o !== 1'b0) begin
      failures++; $display("FAIL idle_after_reset got=%b%b exp=00", bus.busy_o, bus.arvalid_o); end
  endtask

  task automatic test_basic();
    bit bs, to;
    logic [31:0] ea [3] = '{32'h1000, 32'h1004, 32'h1008};
    logic [31:0] ew [3] = '{32'hA1, 32'hB2, 32'hC3};
    tab[0] = 32'hA1; tab[1] = 32'hB2; tab[2] = 32'hC3; tab[3] = 32'h0;
    cfg_tab_en = 1; cfg_ar_rand = 0; cfg_ar_max = 0; cfg_r_rand = 0; cfg_r_max = 0;
    cfg_ready_pct = 100; cfg_hold = 0; cfg_err_beat = -1;
    run_xfer(32'h0000_1002, 16'd3, bs, to);
    cfg_tab_en = 0;
    checks++; if (to) begin failures++; $display("FAIL basic_timeout got=no_done exp=done"); end
    checks++; if (!bs) begin failures++; $display("FAIL basic_busy got=0 exp=1"); end
    checks++; if (ar_log.size() != 3) begin failures++; $display("FAIL basic_ar_count got=%0d exp=3", ar_log.size()); end
    for (int i = 0; i < 3 && i < ar_log.size(); i++) begin
      checks++; if (ar_log[i] !== ea[i]) begin failures++; $display("FAIL basic_araddr[%0d] got=%h exp=%h", i, ar_log[i], ea[i]); end
    end
    checks++; if (out_log.size() != 3) begin failures++; $display("FAIL basic_out_count got=%0d exp=3", out_log.size()); end
    for (int i = 0; i < 3 && i < out_log.size(); i++) begin
      checks++; if (out_log[i] !== ew[i]) begin failures++; $display("FAIL basic_data[%0d] got=%h exp=%h", i, out_log[i], ew[i]); end
    end
    checks++; if (bus.words_done_o !== 16'd3) begin failures++; $display("FAIL basic_words_done got=%0d exp=3", bus.words_done_o); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt); end
    checks++; if (bus.error_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      failures++; $display("FAIL basic_err_busy got=%b%b exp=00", bus.error_o, bus.busy_o); end
  endtask

  task automatic test_zero_count();
    tick();
    epoch++;
    bus.base_addr_i = $urandom; bus.word_count_i = '0; bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    checks++; if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b1) begin
      failures++; $display("FAIL zero_cycle1 got=done%b busy%b exp=done0 busy1", bus.done_o, bus.busy_o); end
    tick();
    checks++; if (bus.done_o !== 1'b1 || bus.busy_o !== 1'b0) begin
      failures++; $display("FAIL zero_cycle2 got=done%b busy%b exp=done1 busy0", bus.done_o, bus.busy_o); end
    tick();
    checks++; if (bus.done_o !== 1'b0) begin failures++; $display("FAIL zero_pulse_width got=%b exp=0", bus.done_o); end
    tick();
    checks++; if (ar_log.size() != 0 || bus.words_done_o !== '0 || bus.error_o !== 1'b0) begin
      failures++; $display("FAIL zero_activity got=ar%0d wd%0d err%b exp=ar0 wd0 err0", ar_log.size(), bus.words_done_o, bus.error_o); end
  endtask

  task automatic test_backpressure();
    bit bs, to;
    logic [31:0] base;
    base = 32'h0002_0000 + ($urandom & 32'h0000_0FFF);
    cfg_ar_max = 0; cfg_r_max = 0; cfg_ready_pct = 100; cfg_hold = 10; cfg_err_beat = -1;
    run_xfer(base, 16'd4, bs, to);
    cfg_hold = 0;
    checks++; if (to) begin failures++; $display("FAIL bp_timeout got=no_done exp=done"); end
    checks++; if (stall_cyc < 10) begin failures++; $display("FAIL bp_stall_cycles got=%0d exp>=10", stall_cyc); end
    checks++; if (stab_viol != 0) begin failures++; $display("FAIL bp_data_stable got=%0d changes exp=0", stab_viol); end
    checks++; if (hold_r_cnt != 0) begin failures++; $display("FAIL bp_r_while_full got=%0d exp=0", hold_r_cnt); end
    checks++; if (out_log.size() != 4) begin failures++; $display("FAIL bp_out_count got=%0d exp=4", out_log.size()); end
    for (int i = 0; i < 4 && i < out_log.size(); i++) begin
      logic [31:0] exp_w;
      exp_w = mem_word((base & 32'hFFFF_FFFC) + 32'(4 * i));
      checks++; if (out_log[i] !== exp_w) begin failures++; $display("FAIL bp_data[%0d] got=%h exp=%h", i, out_log[i], exp_w); end
    end
    checks++; if (bus.words_done_o !== 16'd4) begin failures++; $display("FAIL bp_words_done got=%0d exp=4", bus.words_done_o); end
  endtask

  task automatic test_slverr();
    bit bs, to;
    logic [31:0] base;
    base = $urandom & 32'h00FF_FFFC;
    cfg_ar_rand = 1; cfg_ar_max = 2; cfg_r_rand = 1; cfg_r_max = 2; cfg_ready_pct = 100; cfg_err_beat = 1;
    run_xfer(base, 16'd5, bs, to);
    cfg_err_beat = -1;
    checks++; if (to) begin failures++; $display("FAIL slverr_timeout got=no_done exp=done"); end
    checks++; if (ar_log.size() != 2) begin failures++; $display("FAIL slverr_ar_count got=%0d exp=2", ar_log.size()); end
    checks++; if (out_log.size() != 1 || (out_log.size() == 1 && out_log[0] !== mem_word(base))) begin
      failures++; $display("FAIL slverr_out got=%0d words exp=1 word %h", out_log.size(), mem_word(base)); end
    checks++; if (bus.error_o !== 1'b1) begin failures++; $display("FAIL slverr_error got=%b exp=1", bus.error_o); end
    checks++; if (bus.words_done_o !== 16'd1 || done_cnt != 1) begin
      failures++; $display("FAIL slverr_done got=wd%0d pulses%0d exp=wd1 pulses1", bus.words_done_o, done_cnt); end
  endtask

  task automatic test_abort();
    bit bs, to, seen;
    logic [31:0] base;
    base = 32'h0040_0000;
    cfg_ar_rand = 0; cfg_ar_max = 5; cfg_r_rand = 0; cfg_r_max = 0; cfg_ready_pct = 100; cfg_hold = 0;
    tick();
    epoch++;
    bus.base_addr_i = base; bus.word_count_i = 16'd4; bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.arvalid_o) begin seen = 1; break; end
      tick();
    end
    checks++; if (!seen) begin failures++; $display("FAIL abort_no_arvalid got=0 exp=1"); end
    bus.abort_i = 1'b1;
    tick();
    bus.abort_i = 1'b0;
    checks++; if (bus.arvalid_o !== 1'b1) begin failures++; $display("FAIL abort_ar_withdrawn got=%b exp=1", bus.arvalid_o); end
    to = 1;
    for (int i = 0; i < 100; i++) begin
      if (done_cnt != 0) begin to = 0; break; end
      tick();
    end
    tick(); tick();
    checks++; if (to) begin failures++; $display("FAIL abort_timeout got=no_done exp=done"); end
    checks++; if (ar_viol != 0) begin failures++; $display("FAIL abort_ar_stable got=%0d exp=0", ar_viol); end
    checks++; if (ar_log.size() != 1 || r_hs_cnt != 1) begin
      failures++; $display("FAIL abort_axi got=ar%0d r%0d exp=ar1 r1", ar_log.size(), r_hs_cnt); end
    checks++; if (out_log.size() != 0 || bus.words_done_o !== '0) begin
      failures++; $display("FAIL abort_discard got=%0d/%0d exp=0/0", out_log.size(), bus.words_done_o); end
    checks++; if (bus.error_o !== 1'b1 || done_cnt != 1) begin
      failures++; $display("FAIL abort_flags got=err%b pulses%0d exp=err1 pulses1", bus.error_o, done_cnt); end

    // Abort while the sink holds the last word: the word is dropped at once.
    cfg_ar_max = 0; cfg_hold = 8;
    tick();
    epoch++;
    bus.base_addr_i = 32'h0000_0800; bus.word_count_i = 16'd1; bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.data_valid_o) begin seen = 1; break; end
      tick();
    end
    bus.abort_i = 1'b1;
    tick();
    bus.abort_i = 1'b0;
    tick(); tick();
    cfg_hold = 0;
    checks++; if (!seen || done_cnt != 1) begin
      failures++; $display("FAIL drain_abort_fast got=seen%b pulses%0d exp=seen1 pulses1", seen, done_cnt); end
    checks++; if (out_log.size() != 0 || bus.words_done_o !== '0 || bus.data_valid_o !== 1'b0) begin
      failures++; $display("FAIL drain_abort_drop got=%0d/%0d/%b exp=0/0/0", out_log.size(), bus.words_done_o, bus.data_valid_o); end
    repeat (10) tick();

    run_xfer(32'h0000_0100, 16'd1, bs, to);
    checks++; if (to || bus.error_o !== 1'b0 || bus.words_done_o !== 16'd1) begin
      failures++; $display("FAIL abort_error_cleared got=to%b err%b wd%0d exp=to0 err0 wd1", to, bus.error_o, bus.words_done_o); end
  endtask

  task automatic test_ignore_start();
    bit to;
    logic [31:0] base;
    base = 32'h0010_0010;
    cfg_ar_max = 0; cfg_r_rand = 0; cfg_r_max = 3; cfg_ready_pct = 100;
    tick();
    epoch++;
    bus.base_addr_i = base; bus.word_count_i = 16'd3; bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    repeat (4) tick();
    bus.base_addr_i = 32'h8000_0000; bus.word_count_i = 16'd9; bus.start_i = 1'b1; bus.abort_i = 1'b0;
    tick();
    bus.start_i = 1'b0;
    to = 1;
    for (int i = 0; i < 200; i++) begin
      if (done_cnt != 0) begin to = 0; break; end
      tick();
    end
    tick(); tick();
    checks++; if (to || ar_log.size() != 3) begin failures++; $display("FAIL busy_start got=to%b ar%0d exp=to0 ar3", to, ar_log.size()); end
    for (int i = 0; i < 3 && i < ar_log.size(); i++) begin
      checks++; if (ar_log[i] !== base + 32'(4 * i)) begin
        failures++; $display("FAIL busy_start_addr[%0d] got=%h exp=%h", i, ar_log[i], base + 32'(4 * i)); end
    end
    // Abort in IDLE must not leave anything behind for the next transfer.
    bus.abort_i = 1'b1;
    tick();
    bus.abort_i = 1'b0;
    cfg_r_max = 0;
    begin
      bit bs, to2;
      run_xfer(32'h0000_0200, 16'd2, bs, to2);
      checks++; if (to2 || bus.error_o !== 1'b0 || bus.words_done_o !== 16'd2) begin
        failures++; $display("FAIL idle_abort got=to%b err%b wd%0d exp=to0 err0 wd2", to2, bus.error_o, bus.words_done_o); end
    end
  endtask

  task automatic test_wrap_reset();
    bit bs, to, seen;
    cfg_ar_max = 0; cfg_r_rand = 0; cfg_r_max = 0; cfg_ready_pct = 100;
    run_xfer(32'hFFFF_FFFC, 16'd2, bs, to);
    checks++; if (to || ar_log.size() != 2) begin failures++; $display("FAIL wrap_count got=to%b ar%0d exp=to0 ar2", to, ar_log.size()); end
    if (ar_log.size() == 2) begin
      checks++; if (ar_log[0] !== 32'hFFFF_FFFC || ar_log[1] !== 32'h0000_0000) begin
        failures++; $display("FAIL wrap_addr got=%h,%h exp=fffffffc,00000000", ar_log[0], ar_log[1]); end
    end
    checks++; if (out_log.size() != 2 || (out_log.size() == 2 && out_log[1] !== mem_word(32'h0))) begin
      failures++; $display("FAIL wrap_data got=%0d words exp=2 ending %h", out_log.size(), mem_word(32'h0)); end

    cfg_r_max = 8;
    tick();
    epoch++;
    bus.base_addr_i = 32'h0000_3000; bus.word_count_i = 16'd6; bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (ar_log.size() == 1) begin seen = 1; break; end
      tick();
    end
    checks++; if (!seen || bus.rready_o !== 1'b1 || bus.busy_o !== 1'b1) begin
      failures++; $display("FAIL midr_setup got=seen%b rready%b busy%b exp=111", seen, bus.rready_o, bus.busy_o); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({bus.arvalid_o, bus.rready_o, bus.data_valid_o, bus.busy_o, bus.done_o, bus.error_o} !== 6'b0) begin
      failures++; $display("FAIL midr_reset_flags got=%b exp=000000",
        {bus.arvalid_o, bus.rready_o, bus.data_valid_o, bus.busy_o, bus.done_o, bus.error_o}); end
    checks++; if (bus.araddr_o !== '0 || bus.words_done_o !== '0 || bus.data_o !== '0) begin
      failures++; $display("FAIL midr_reset_regs got=%h/%0d/%h exp=0/0/0", bus.araddr_o, bus.words_done_o, bus.data_o); end
    tick(); tick();
    reset = 1'b0;
    cfg_r_max = 0;
    run_xfer(32'h0000_0040, 16'd2, bs, to);
    checks++; if (to || out_log.size() != 2 || bus.words_done_o !== 16'd2) begin
      failures++; $display("FAIL after_reset got=to%b out%0d wd%0d exp=to0 out2 wd2", to, out_log.size(), bus.words_done_o); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      bit bs, to;
      logic [31:0] base;
      int cnt, err_beat, n_ok, n_ar;
      base = $urandom;
      cnt  = ($urandom_range(9, 0) < 2) ? 0 : int'($urandom_range(10, 1));
      err_beat = (cnt > 0 && $urandom_range(3, 0) == 0) ? int'($urandom_range(cnt - 1, 0)) : -1;
      cfg_ar_rand = 1; cfg_ar_max = int'($urandom_range(3, 0));
      cfg_r_rand  = 1; cfg_r_max  = int'($urandom_range(3, 0));
      cfg_ready_pct = int'($urandom_range(100, 40)); cfg_err_beat = err_beat; cfg_hold = 0;
      n_ok = (err_beat < 0) ? cnt : err_beat;
      n_ar = (err_beat < 0) ? cnt : err_beat + 1;
      run_xfer(base, 16'(cnt), bs, to);
      checks++; if (to) begin failures++; $display("FAIL rnd%0d_timeout got=no_done exp=done", it); end
      checks++; if (ar_log.size() != n_ar) begin failures++; $display("FAIL rnd%0d_ar_count got=%0d exp=%0d", it, ar_log.size(), n_ar); end
      for (int i = 0; i < n_ar && i < ar_log.size(); i++) begin
        logic [31:0] ea;
        ea = (base & 32'hFFFF_FFFC) + 32'(4 * i);
        checks++; if (ar_log[i] !== ea) begin failures++; $display("FAIL rnd%0d_araddr[%0d] got=%h exp=%h", it, i, ar_log[i], ea); end
      end
      checks++; if (out_log.size() != n_ok) begin failures++; $display("FAIL rnd%0d_out_count got=%0d exp=%0d", it, out_log.size(), n_ok); end
      for (int i = 0; i < n_ok && i < out_log.size(); i++) begin
        logic [31:0] ew;
        ew = mem_word((base & 32'hFFFF_FFFC) + 32'(4 * i));
        checks++; if (out_log[i] !== ew) begin failures++; $display("FAIL rnd%0d_data[%0d] got=%h exp=%h", it, i, out_log[i], ew); end
      end
      checks++; if (bus.words_done_o !== 16'(n_ok)) begin failures++; $display("FAIL rnd%0d_words_done got=%0d exp=%0d", it, bus.words_done_o, n_ok); end
      checks++; if (bus.error_o !== (err_beat >= 0)) begin failures++; $display("FAIL rnd%0d_error got=%b exp=%b", it, bus.error_o, err_beat >= 0); end
      checks++; if (done_cnt != 1 || bus.busy_o !== 1'b0) begin
        failures++; $display("FAIL rnd%0d_done got=pulses%0d busy%b exp=pulses1 busy0", it, done_cnt, bus.busy_o); end
      checks++; if (ar_viol != 0 || stab_viol != 0 || hold_r_cnt != 0) begin
        failures++; $display("FAIL rnd%0d_protocol got=ar%0d data%0d r%0d exp=0/0/0", it, ar_viol, stab_viol, hold_r_cnt); end
    end
  endtask

  initial begin : main
    bus.start_i = 1'b0; bus.abort_i = 1'b0; bus.base_addr_i = '0; bus.word_count_i = '0;
    test_reset();
    test_basic();
    test_zero_count();
    test_backpressure();
    test_slverr();
    test_abort();
    test_ignore_start();
    test_wrap_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/xip_burst_reader.md
Name: xip_burst_reader

Overview:
- AXI4-Lite read master that fetches a block of 32-bit words from the memory-mapped XIP flash window. Typical uses are boot copy and the CRC/verify engine.
- Takes a base address and word count from its control interface, then issues sequential single-beat AR/R transactions.
- Each returned word goes to a valid/ready output stream.
- Connects directly to the XIP engine's AXI4-Lite slave read channels. That slave accepts one read at a time, so this master keeps at most one AR outstanding.

Parameters:
ADDR_WIDTH, 32, width of AXI read address and base address.
CNT_WIDTH, 16, width of word count and progress counter.

Ports:
clk  input  1  clock; all logic on rising edge.
reset  input  1  asynchronous, active-high reset.
start_i  input  1  begin transfer; sampled only in IDLE.
base_addr_i  input  ADDR_WIDTH  start byte address; bits [1:0] ignored (forced 0).
word_count_i  input  CNT_WIDTH  number of 32-bit words to read.
abort_i  input  1  stop transfer after the in-flight transaction.
araddr_o  output  ADDR_WIDTH  AXI read address.
arvalid_o  output  1  AXI read address valid.
arready_i  input  1  AXI read address ready.
rdata_i  input  32  AXI read data.
rresp_i  input  2  AXI read response.
rvalid_i  input  1  AXI read data valid.
rready_o  output  1  AXI read data ready.
data_o  output  32  output stream word.
data_valid_o  output  1  output word valid.
data_ready_i  input  1  sink accepts word.
busy_o  output  1  transfer in progress.
done_o  output  1  one-cycle pulse at transfer end.
error_o  output  1  sticky: last transfer saw non-OKAY rresp or was aborted; cleared on next accepted start.
words_done_o  output  CNT_WIDTH  words delivered to sink in current/last transfer.

Behaviour:
Reset:
- All outputs are 0. State is IDLE. Address and count registers are 0.
- Asynchronous assertion mid-transfer drops everything; no AXI completion is awaited.

States: IDLE, AR, R, DRAIN, FIN.

IDLE:
- start_i=1 latches addr = {base_addr_i[ADDR_WIDTH-1:2],2'b00} and remaining = word_count_i.
- Clears error_o and words_done_o; sets busy_o=1.
- If word_count_i==0, go to FIN (no AXI activity). Otherwise go to AR; arvalid_o=1 in the next cycle.

AR:
- arvalid_o held high and araddr_o stable until arready_i; AXI rule, no withdrawal, even on abort.
- On handshake: arvalid_o drops next cycle; go to R.

R:
- rready_o=1 when the output register is empty or is being drained this cycle (data_valid_o && data_ready_i).
- On rvalid_i && rready_o:
  - If rresp_i==2'b00: load data_o, data_valid_o=1 next cycle, addr += 4 (wraps modulo 2^ADDR_WIDTH), remaining -= 1.
  - If rresp_i!=2'b00: word discarded, error_o=1, go to DRAIN.
  - If remaining becomes 0, or abort is pending: go to DRAIN.
  - Else go to AR; the next arvalid_o asserts the cycle after the R handshake. This overlaps with the sink holding the prior word.

DRAIN:
- Wait until the output register is empty (last word accepted by the sink), then go to FIN.
- On abort, the pending output word is dropped immediately instead of waiting for the sink.

FIN:
- done_o=1 and busy_o=0 for exactly one cycle, then go to IDLE.

Output stream:
- data_o is stable while data_valid_o && !data_ready_i.
- words_done_o increments on each data_valid_o && data_ready_i.

Abort:
- abort_i is latched as abort pending (cleared on entering IDLE).
- In AR/R, the current AXI transaction completes; its data is discarded. Go to DRAIN, then FIN.
- Sets error_o=1.
- Ignored in IDLE and FIN.

Other rules:
- start_i while busy is ignored.
- rvalid_i outside R is ignored (protocol error by slave; no state change).

Test Plan:
- base=0x0000_1002, count=3, slave returns 0xA1,0xB2,0xC3 with 1-cycle arready/rvalid, sink always ready -> araddr 0x1000,0x1004,0x1008; data_o A1,B2,C3; words_done_o=3; done_o one pulse; error_o=0.
- count=0 -> no arvalid_o; done_o pulses 2 cycles after start; words_done_o=0.
- count=4, data_ready_i low 10 cycles after first word -> data_o held at word0; at most one further R accepted (rready_o low until drain); all 4 words delivered in order.
- 2nd beat returns rresp=2'b10 -> word dropped, error_o=1, no 3rd AR, done_o pulses, words_done_o=1.
- abort_i while arvalid_o high and arready_i low for 5 cycles -> arvalid_o held until handshake, R beat consumed and discarded, done_o pulses, error_o=1.
- base=0xFFFF_FFFC, count=2 -> araddr 0xFFFF_FFFC then 0x0000_0000; reset asserted mid-R -> all outputs 0 immediately.
